apb_mem_responder: RTL and testbench
====================================

APB_MEM_RESPONDER -- requirements
Module: apb_mem_responder

Interface
REQ-001 SHALL have parameter BITS, default 16, data word width.
REQ-002 SHALL have parameter DEPTH, default 256, number of words; legal addresses 0..DEPTH-1.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15, number of PREADY-low cycles per transfer.
REQ-004 SHALL have port CLOCK  input  1  clock, all state on rising edge.
REQ-005 SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port PSEL  input  1  responder selected.
REQ-007 SHALL have port PENABLE  input  1  access phase indicator.
REQ-008 SHALL have port PWRITE  input  1  1=write, 0=read.
REQ-009 SHALL have port PADDR  input  11  word address.
REQ-010 SHALL have port PWDATA  input  BITS  write data.
REQ-011 SHALL have port PRDATA  output  BITS  read data.
REQ-012 SHALL have port PREADY  output  1  transfer completes this cycle.
REQ-013 SHALL have port PSLVERR  output  1  transfer error, qualified by PREADY.
REQ-014 SHALL have port ERR_CNT  output  8  saturating count of errored transfers.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, ACCESS.
REQ-016 IDLE -> ACCESS on a rising edge with PSEL=1, PENABLE=0; at that edge SHALL capture PADDR, PWRITE and PWDATA into internal registers and load the wait counter with WAIT_STATES.
REQ-017 In IDLE, PSEL=1 with PENABLE=1 (no setup phase) SHALL be ignored; FSM stays IDLE, PREADY=0.
REQ-018 In ACCESS, PREADY SHALL equal 1 combinationally when the wait counter is 0, else 0; the counter SHALL decrement by 1 on each ACCESS edge while nonzero.
REQ-019 Transfer latency SHALL be WAIT_STATES+1 ACCESS cycles; WAIT_STATES=0 gives PREADY=1 on the first ACCESS cycle.
REQ-020 ACCESS -> IDLE on the edge ending the completion cycle (PSEL=1, PENABLE=1, PREADY=1).
REQ-021 Abort: PSEL=0 or PENABLE=0 in any ACCESS cycle SHALL return the FSM to IDLE at the next edge with no memory write and no ERR_CNT change.
REQ-022 Error: a captured address >= DEPTH SHALL give PSLVERR=1 in the completion cycle, no memory write and PRDATA=0.
REQ-023 PSLVERR SHALL be 0 in every cycle where PREADY=0.
REQ-024 Write: on the completion edge with captured PWRITE=1 and no error, mem[addr] SHALL take the captured PWDATA; PWDATA changes after setup SHALL be ignored.
REQ-025 Read: in the completion cycle with captured PWRITE=0 and no error, PRDATA SHALL equal mem[addr]; PRDATA SHALL be 0 in all other cycles.
REQ-026 A read from an address in the cycle after a write to the same address SHALL return the new data.
REQ-027 Back-to-back: after completion, a new setup phase SHALL be accepted on the very next edge (no idle cycle required).
REQ-028 ERR_CNT SHALL increment by 1 on each errored completion edge and saturate at 8'hFF.
REQ-029 Memory SHALL be a DEPTH x BITS register array, write-only through REQ-024, with no other write path.

Reset
REQ-030 RESETn=0 SHALL immediately force FSM=IDLE, wait counter=0, captured registers=0, ERR_CNT=0, PREADY=0, PSLVERR=0, PRDATA=0.
REQ-031 Memory contents SHALL NOT be cleared by reset and are undefined until written.
REQ-032 Reset asserted during ACCESS SHALL abort the transfer with no memory write.

Verification
REQ-033 WAIT_STATES=1: write 0x00A5 to addr 0x010, then read 0x010 -> each transfer has PREADY low 1 cycle then high 1 cycle; read returns PRDATA=0x00A5, PSLVERR=0.
REQ-034 Read from addr 0x100 (DEPTH=256) -> completion with PREADY=1, PSLVERR=1, PRDATA=0, ERR_CNT 0->1; write to 0x7FF -> no memory change, ERR_CNT=2.
REQ-035 WAIT_STATES=0: back-to-back writes of 0x1111 to addr 0x001 and 0x2222 to addr 0x002, then reads -> each transfer 2 cycles total, reads return 0x1111 and 0x2222.
REQ-036 Drop PSEL mid-ACCESS of a write of 0xBEEF to addr 0x020 that previously held 0x0001 -> FSM IDLE, read of 0x020 returns 0x0001, ERR_CNT unchanged.
REQ-037 Issue 260 errored transfers -> ERR_CNT holds 0xFF; pulse RESETn low during ACCESS -> ERR_CNT=0, PREADY=0 immediately.
REQ-038 PENABLE=1 with PSEL=1 while IDLE without a setup phase -> PREADY remains 0 and FSM stays IDLE.

Source files
------------

// File: rtl/apb_mem_responder.sv
// APB word-addressed memory responder with programmable wait states.
// Addresses at or beyond DEPTH complete with PSLVERR and are counted in ERR_CNT.
module apb_mem_responder #(
  parameter int unsigned BITS        = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            CLOCK,
  input  logic            RESETn,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [10:0]     PADDR,
  input  logic [BITS-1:0] PWDATA,
  output logic [BITS-1:0] PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  output logic [7:0]      ERR_CNT
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]      r_state;
  logic [3:0]      r_wait;
  logic [10:0]     r_addr;
  logic            r_write;
  logic [BITS-1:0] r_wdata;
  logic [7:0]      r_err_cnt;
  logic [BITS-1:0] r_mem [DEPTH];

  logic w_setup;
  logic w_ready;
  logic w_err;
  logic w_complete;
  logic w_abort;

  // A setup phase is only recognised from IDLE with PENABLE still low.
  assign w_setup    = (r_state == S_IDLE) && PSEL && !PENABLE;
  assign w_ready    = (r_state == S_ACCESS) && (r_wait == 4'd0);
  assign w_err      = (32'(r_addr) >= DEPTH);
  assign w_complete = w_ready && PSEL && PENABLE;
  assign w_abort    = (r_state == S_ACCESS) && !(PSEL && PENABLE);

  // FSM, wait counter and captured transfer attributes.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_state <= S_ACCESS;
            r_wait  <= 4'(WAIT_STATES);
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
          end
        end
        S_ACCESS: begin
          if (w_abort || w_complete) begin
            r_state <= S_IDLE;
          end else if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of errored completions.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      r_err_cnt <= 8'd0;
    end else if (w_complete && w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Storage is deliberately not reset; the only write path is a clean write completion.
  always_ff @(posedge CLOCK) begin
    if (w_complete && r_write && !w_err) begin
      r_mem[r_addr[AW-1:0]] <= r_wdata;
    end
  end

  // Read data is driven only in a clean read completion cycle, zero otherwise.
  always_comb begin
    PRDATA = '0;
    if (w_ready && !r_write && !w_err) begin
      PRDATA = r_mem[r_addr[AW-1:0]];
    end
  end

  assign PREADY  = w_ready;
  assign PSLVERR = w_ready && w_err;
  assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_apb_mem_responder.sv
// Directed bench: one responder with one wait state, one with none, sharing the APB bus.
module tb_apb_mem_responder;

  logic        CLOCK   = 1'b0;
  logic        RESETn  = 1'b0;
  logic        PSEL    = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [10:0] PADDR   = '0;
  logic [15:0] PWDATA  = '0;

  logic [15:0] prdata1, prdata0;
  logic        pready1, pready0, pslverr1, pslverr0;
  logic [7:0]  err_cnt1, err_cnt0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 CLOCK = ~CLOCK;

  apb_mem_responder #(.BITS(16), .DEPTH(256), .WAIT_STATES(1)) u_dut1 (
    .CLOCK(CLOCK), .RESETn(RESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .ERR_CNT(err_cnt1)
  );

  apb_mem_responder #(.BITS(16), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .CLOCK(CLOCK), .RESETn(RESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .ERR_CNT(err_cnt0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the completion edge.
  task automatic xfer(input bit use0, input bit wr, input logic [10:0] a,
                      input logic [15:0] wd, input logic [15:0] exp_rd, input bit exp_err);
    exp_t e;
    int   cycles;
    bit   done;
    logic rdy, serr;
    logic [15:0] rd;
    e.rd  = exp_rd;
    e.err = exp_err;
    e.lat = use0 ? 1 : 2;
    sb.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge CLOCK); #1;
    PENABLE = 1'b1;
    PWDATA  = ~wd;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 20) begin
      @(negedge CLOCK);
      cycles++;
      rdy  = use0 ? pready0 : pready1;
      serr = use0 ? pslverr0 : pslverr1;
      rd   = use0 ? prdata0 : prdata1;
      if (rdy) begin
        e = sb.pop_front();
        check("latency", 32'(cycles), 32'(e.lat));
        check("pslverr", {31'd0, serr}, {31'd0, e.err});
        check("prdata", {16'd0, rd}, {16'd0, e.rd});
        done = 1'b1;
      end else begin
        check("wait_pslverr", {31'd0, serr}, 32'd0);
        check("wait_prdata", {16'd0, rd}, 32'd0);
      end
      @(posedge CLOCK); #1;
    end
    if (!done) check("timeout", 32'(cycles), 32'(e.lat));
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    // Reset values while RESETn is held low.
    #2;
    check("rst_pready", {31'd0, pready1}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr1}, 32'd0);
    check("rst_prdata", {16'd0, prdata1}, 32'd0);
    check("rst_errcnt", {24'd0, err_cnt1}, 32'd0);
    check("rst_pready0", {31'd0, pready0}, 32'd0);
    @(posedge CLOCK); @(posedge CLOCK); #1;
    RESETn = 1'b1;
    @(posedge CLOCK); #1;

    // Access phase without setup must be ignored by both responders.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 11'h010; PWDATA = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      check("nosetup_pready1", {31'd0, pready1}, 32'd0);
      check("nosetup_pready0", {31'd0, pready0}, 32'd0);
      @(posedge CLOCK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge CLOCK); #1;

    // One wait state: write then immediate read of the same word.
    xfer(1'b0, 1'b1, 11'h010, 16'h00A5, 16'h0000, 1'b0);
    xfer(1'b0, 1'b0, 11'h010, 16'h0000, 16'h00A5, 1'b0);

    // Out-of-range accesses error, count, and leave memory untouched.
    xfer(1'b0, 1'b0, 11'h100, 16'h0000, 16'h0000, 1'b1);
    check("errcnt_1", {24'd0, err_cnt1}, 32'd1);
    xfer(1'b0, 1'b1, 11'h0FF, 16'h1234, 16'h0000, 1'b0);
    xfer(1'b0, 1'b1, 11'h7FF, 16'hDEAD, 16'h0000, 1'b1);
    check("errcnt_2", {24'd0, err_cnt1}, 32'd2);
    xfer(1'b0, 1'b0, 11'h0FF, 16'h0000, 16'h1234, 1'b0);

    // Zero wait states, back-to-back transfers.
    xfer(1'b1, 1'b1, 11'h001, 16'h1111, 16'h0000, 1'b0);
    xfer(1'b1, 1'b1, 11'h002, 16'h2222, 16'h0000, 1'b0);
    xfer(1'b1, 1'b0, 11'h001, 16'h0000, 16'h1111, 1'b0);
    xfer(1'b1, 1'b0, 11'h002, 16'h0000, 16'h2222, 1'b0);

    // Aborted write leaves the old word in place.
    xfer(1'b0, 1'b1, 11'h020, 16'h0001, 16'h0000, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 11'h020; PWDATA = 16'hBEEF;
    @(posedge CLOCK); #1;
    PENABLE = 1'b1;
    @(negedge CLOCK);
    check("abort_pready", {31'd0, pready1}, 32'd0);
    @(posedge CLOCK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge CLOCK); #1;
    @(negedge CLOCK);
    check("abort_idle", {31'd0, pready1}, 32'd0);
    @(posedge CLOCK); #1;
    xfer(1'b0, 1'b0, 11'h020, 16'h0000, 16'h0001, 1'b0);
    check("abort_errcnt", {24'd0, err_cnt1}, 32'd2);

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      xfer(1'b0, 1'b0, 11'h100 + 11'(i), 16'h0000, 16'h0000, 1'b1);
    end
    check("errcnt_sat", {24'd0, err_cnt1}, 32'hFF);

    // Reset pulse in the completion cycle of a write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 11'h010; PWDATA = 16'h5555;
    @(posedge CLOCK); #1;
    PENABLE = 1'b1;
    @(posedge CLOCK); #1;
    check("rstacc_ready_before", {31'd0, pready1}, 32'd1);
    RESETn = 1'b0;
    #1;
    check("rstacc_pready", {31'd0, pready1}, 32'd0);
    check("rstacc_errcnt", {24'd0, err_cnt1}, 32'd0);
    @(posedge CLOCK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    RESETn = 1'b1;
    @(posedge CLOCK); #1;
    xfer(1'b0, 1'b0, 11'h010, 16'h0000, 16'h00A5, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
